// File: rtl/hamming_engine_if.sv
// Host/memory bundle for hamming_engine: run handshake, byte memory port and error counters.
// The engine drives the memory bus and status through the master modport; the host and
// memory model sit on the slave side.
`timescale 1ns/1ps

interface hamming_engine_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req;
    logic              mode;
    logic              ack;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic [7:0]        mem_rd_data;
    logic [7:0]        sec_cnt;
    logic [7:0]        ded_cnt;

    modport master (
        input  req,
        input  mode,
        input  mem_rd_data,
        output ack,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        output sec_cnt,
        output ded_cnt
    );

    modport slave (
        output req,
        output mode,
        output mem_rd_data,
        input  ack,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        input  sec_cnt,
        input  ded_cnt
    );
endinterface

// File: rtl/hamming_engine.sv
// SECDED Hamming(16,11) engine. Each run walks NUM_MSG messages in a byte memory, reading
// two source bytes and writing two result bytes per message (4 cycles per message).
// mode=0 encodes 11 data bits into a codeword; mode=1 checks/corrects a codeword and
// writes the data back with a 2-bit status flag in the top of the high byte.
`timescale 1ns/1ps

module hamming_engine #(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned ADDR_W   = 8
) (
    input logic              clock,
    input logic              reset,
    hamming_engine_if.master bus
);

    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] SRC_A = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       lo_q, lo_d;
    logic [7:0]       hi_q, hi_d;
    logic             mode_q, mode_d;
    logic [7:0]       sec_q, sec_d;
    logic [7:0]       ded_q, ded_d;

    logic             last;
    logic [ADDR_W-1:0] pair_off;

    logic [15:0]      enc_c;
    logic [3:0]       enc_p;
    logic [15:0]      dec_in;
    logic [15:0]      dec_c;
    logic [3:0]       dec_syn;
    logic             dec_par;
    logic [1:0]       dec_flag;
    logic [7:0]       dec_lo;
    logic [7:0]       dec_hi;

    assign last     = (idx_q == LAST_IDX);
    assign pair_off = {idx_q, 1'b0};

    // Encoder: place data at non-power-of-two positions, then the syndrome of the
    // data-only word is exactly {p8,p4,p2,p1}; p0 makes overall parity even.
    always_comb begin
        enc_c      = '0;
        enc_c[3]   = lo_q[0];
        enc_c[7:5] = lo_q[3:1];
        enc_c[15:9] = {hi_q[2:0], lo_q[7:4]};
        enc_p = '0;
        for (int k = 1; k < 16; k++) begin
            if (enc_c[k]) enc_p = enc_p ^ 4'(k);
        end
        enc_c[1] = enc_p[0];
        enc_c[2] = enc_p[1];
        enc_c[4] = enc_p[2];
        enc_c[8] = enc_p[3];
        enc_c[0] = ^enc_c[15:1];
    end

    // Decoder: syndrome locates a single flipped bit (0 means p0); odd overall parity
    // marks a correctable error, even parity with nonzero syndrome a double error.
    always_comb begin
        dec_in  = {hi_q, lo_q};
        dec_syn = '0;
        for (int k = 1; k < 16; k++) begin
            if (dec_in[k]) dec_syn = dec_syn ^ 4'(k);
        end
        dec_par  = ^dec_in;
        dec_c    = dec_in;
        dec_flag = 2'b00;
        if (dec_par) begin
            dec_c[dec_syn] = ~dec_in[dec_syn];
            dec_flag       = 2'b01;
        end else if (dec_syn != 4'd0) begin
            dec_flag = 2'b10;
        end
        dec_lo = {dec_c[12:9], dec_c[7:5], dec_c[3]};
        dec_hi = {dec_flag, 3'b000, dec_c[15:13]};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-step walk per message; req only matters when idle/done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.req) state_d = RD_LO;
            RD_LO:      state_d = RD_HI;
            RD_HI:      state_d = WR_LO;
            WR_LO:      state_d = WR_HI;
            WR_HI:      state_d = last ? DONE : RD_LO;
            default:    state_d = IDLE;
        endcase
    end

    // Output logic: memory port and ack are pure functions of state and datapath.
    always_comb begin
        bus.ack         = (state_q == DONE);
        bus.mem_wr_en   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        case (state_q)
            RD_LO: bus.mem_addr = SRC_A + pair_off;
            RD_HI: bus.mem_addr = SRC_A + pair_off + ADDR_W'(1);
            WR_LO: begin
                bus.mem_addr    = DST_A + pair_off;
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = mode_q ? dec_lo : enc_c[7:0];
            end
            WR_HI: begin
                bus.mem_addr    = DST_A + pair_off + ADDR_W'(1);
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_data = mode_q ? dec_hi : enc_c[15:8];
            end
            default: ;
        endcase
    end

    // Datapath next values: capture source bytes, advance index, count decode outcomes.
    always_comb begin
        idx_d  = idx_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        mode_d = mode_q;
        sec_d  = sec_q;
        ded_d  = ded_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.req) begin
                    idx_d  = '0;
                    sec_d  = '0;
                    ded_d  = '0;
                    mode_d = bus.mode;
                end
            end
            RD_LO: lo_d = bus.mem_rd_data;
            RD_HI: hi_d = bus.mem_rd_data;
            WR_LO: begin
                // Counted once per message; saturate rather than wrap.
                if (mode_q && dec_flag == 2'b01 && sec_q != 8'hFF) sec_d = sec_q + 8'd1;
                if (mode_q && dec_flag == 2'b10 && ded_q != 8'hFF) ded_d = ded_q + 8'd1;
            end
            WR_HI: if (!last) idx_d = idx_q + IDX_W'(1);
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q  <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            mode_q <= 1'b0;
            sec_q  <= '0;
            ded_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            mode_q <= mode_d;
            sec_q  <= sec_d;
            ded_q  <= ded_d;
        end
    end

    assign bus.sec_cnt = sec_q;
    assign bus.ded_cnt = ded_q;

endmodule
